// File: rtl/snd_pkg.sv
// snd_pkg: shared constants, enums and LFSR helper for the snd_synth tone generator.
package snd_pkg;

   localparam logic [1:0] SND_FREQ  = 2'd0;
   localparam logic [1:0] SND_SHAPE = 2'd1;
   localparam logic [1:0] SND_DUTY  = 2'd2;
   localparam logic [1:0] SND_CTRL  = 2'd3;

   localparam int PHASE_W = 16;
   localparam int WAVE_W  = 8;
   localparam int ACC_W   = 14;
   localparam int LFSR_W  = 15;

   typedef enum logic [1:0] {
      WAVE_SQUARE = 2'd0,
      WAVE_SAW    = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_NOISE  = 2'd3
   } wave_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_V0   = 3'd1,
      ST_V1   = 3'd2,
      ST_V2   = 3'd3,
      ST_V3   = 3'd4,
      ST_OUT  = 3'd5
   } state_t;

   // Polynomial x^15 + x^14 + 1, shifting towards the MSB.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], v[14] ^ v[13]};
   endfunction

endpackage

// File: rtl/snd_wavegen.sv
// snd_wavegen: combinational 8-bit signed waveform for one voice, shared by all
// voices through the scan FSM.
module snd_wavegen
   import snd_pkg::*;
(
   input  logic [8:0]        phase_hi,
   input  logic [7:0]        duty,
   input  logic [1:0]        wave_sel,
   input  logic [7:0]        lfsr_lo,
   output logic [WAVE_W-1:0] wave
);

   logic [7:0] p;
   logic [7:0] tri_t;

   always_comb begin
      p     = phase_hi[8:1];
      tri_t = phase_hi[8] ? ~phase_hi[7:0] : phase_hi[7:0];
      wave  = '0;
      case (wave_t'(wave_sel))
         WAVE_SQUARE: wave = (p < duty) ? 8'h7F : 8'h80;
         WAVE_SAW:    wave = p ^ 8'h80;
         WAVE_TRI:    wave = tri_t ^ 8'h80;
         WAVE_NOISE:  wave = lfsr_lo;
         default:     wave = '0;
      endcase
   end

endmodule

// File: rtl/snd_synth.sv
// snd_synth: four-voice tone generator producing one mixed sample every CLK_DIV clocks.
// Macro SND_FRAME_IRQ_EN adds the FRAME_SAMPLES frame counter driving frame_irq.
module snd_synth
   import snd_pkg::*;
#(
   parameter int CLK_DIV = 1042
`ifdef SND_FRAME_IRQ_EN
   , parameter int FRAME_SAMPLES = 800
`endif
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        snd_wen,
   input  logic [1:0]  w_param,
   input  logic [1:0]  w_index,
   input  logic [15:0] w_val,
   output logic [15:0] sample,
   output logic        sample_stb,
   output logic        frame_irq
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   state_t             state, state_next;
   logic [1:0]         vidx;
   logic               vbusy;

   logic [15:0]        freq  [4];
   logic [3:0]         vol   [4];
   logic [1:0]         wsel  [4];
   logic [7:0]         duty  [4];
   logic [3:0]         en;
   logic [PHASE_W-1:0] phase [4];
   logic [LFSR_W-1:0]  lfsr  [4];

   logic [ACC_W-1:0]   acc, acc_next;
   logic [WAVE_W-1:0]  wave_cur;
   logic [11:0]        w_ext, v_ext, contrib;
   logic [PHASE_W:0]   psum;

   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!resetn)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // IDLE waits for tick, V0..V3 each process one voice, OUT strobes the sample.
   always_comb begin
      state_next = state;
      sample_stb = 1'b0;
      vbusy      = 1'b0;
      vidx       = 2'd0;
      case (state)
         ST_IDLE: if (tick) state_next = ST_V0;
         ST_V0:   begin vbusy = 1'b1; vidx = 2'd0; state_next = ST_V1; end
         ST_V1:   begin vbusy = 1'b1; vidx = 2'd1; state_next = ST_V2; end
         ST_V2:   begin vbusy = 1'b1; vidx = 2'd2; state_next = ST_V3; end
         ST_V3:   begin vbusy = 1'b1; vidx = 2'd3; state_next = ST_OUT; end
         ST_OUT:  begin sample_stb = 1'b1; state_next = ST_IDLE; end
         default: state_next = ST_IDLE;
      endcase
   end

   snd_wavegen u_wavegen (
      .phase_hi (phase[vidx][15:7]),
      .duty     (duty[vidx]),
      .wave_sel (wsel[vidx]),
      .lfsr_lo  (lfsr[vidx][7:0]),
      .wave     (wave_cur)
   );

   // The low 12 bits of the product are the same whether read signed or unsigned.
   always_comb begin
      w_ext    = {{4{wave_cur[WAVE_W-1]}}, wave_cur};
      v_ext    = {8'd0, vol[vidx]};
      contrib  = en[vidx] ? (w_ext * v_ext) : 12'd0;
      acc_next = acc + {{(ACC_W - 12){contrib[11]}}, contrib};
      psum     = {1'b0, phase[vidx]} + {1'b0, freq[vidx]};
   end

   // snd_wen is a one-cycle strobe with no back-pressure: every write is taken
   // and becomes visible the following cycle; the scan sees pre-write values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 4; i++) begin
            freq[i]  <= '0;
            vol[i]   <= '0;
            wsel[i]  <= '0;
            duty[i]  <= '0;
            phase[i] <= '0;
            lfsr[i]  <= LFSR_W'(i + 1);
         end
         en     <= '0;
         acc    <= '0;
         sample <= '0;
      end else begin
         if (vbusy && en[vidx]) begin
            phase[vidx] <= psum[PHASE_W-1:0];
            if (psum[PHASE_W])
               lfsr[vidx] <= lfsr_step(lfsr[vidx]);
         end

         if (state == ST_IDLE && tick)
            acc <= '0;
         else if (vbusy)
            acc <= acc_next;

         // Loaded as V3 completes so the value is already stable during the OUT strobe.
         if (state == ST_V3)
            sample <= {acc_next, 2'b00};

         // Placed after the phase update so a clear in the same cycle wins.
         if (snd_wen) begin
            case (w_param)
               SND_FREQ:  freq[w_index] <= w_val;
               SND_SHAPE: begin
                  vol[w_index]  <= w_val[3:0];
                  wsel[w_index] <= w_val[5:4];
               end
               SND_DUTY:  duty[w_index] <= w_val[7:0];
               SND_CTRL:  begin
                  en[w_index] <= w_val[0];
                  if (w_val[1])
                     phase[w_index] <= '0;
               end
            endcase
         end
      end
   end

`ifdef SND_FRAME_IRQ_EN
   localparam int FRM_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;

   logic [FRM_W-1:0] frame_cnt;
   logic             frame_last;

   assign frame_last = (frame_cnt == FRM_W'(FRAME_SAMPLES - 1));
   assign frame_irq  = sample_stb && frame_last;

   always_ff @(posedge clk) begin
      if (!resetn)
         frame_cnt <= '0;
      else if (sample_stb)
         frame_cnt <= frame_last ? '0 : frame_cnt + FRM_W'(1);
   end
`else
   assign frame_irq = 1'b0;
`endif

endmodule

// File: tb/tb_snd_synth.sv
// tb_snd_synth: directed and randomized checks of snd_synth against a sample-level
// reference model of the voices.
`timescale 1ns/1ps
module tb_snd_synth;

  localparam int CLK_DIV = 6;
`ifdef SND_FRAME_IRQ_EN
  localparam int FRAME_SAMPLES = 3;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        snd_wen = 1'b0;
  logic [1:0]  w_param = '0;
  logic [1:0]  w_index = '0;
  logic [15:0] w_val = '0;
  logic [15:0] sample;
  logic        sample_stb;
  logic        frame_irq;

  always #5 clk = ~clk;

  snd_synth #(
    .CLK_DIV(CLK_DIV)
`ifdef SND_FRAME_IRQ_EN
    , .FRAME_SAMPLES(FRAME_SAMPLES)
`endif
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .snd_wen    (snd_wen),
    .w_param    (w_param),
    .w_index    (w_index),
    .w_val      (w_val),
    .sample     (sample),
    .sample_stb (sample_stb),
    .frame_irq  (frame_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  logic [15:0] exp_q[$];

  // ---------------- reference model (per-sample) ----------------
  int m_freq[4], m_vol[4], m_wave[4], m_duty[4], m_en[4], m_phase[4], m_lfsr[4];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_freq[i] = 0; m_vol[i] = 0; m_wave[i] = 0; m_duty[i] = 0;
      m_en[i] = 0; m_phase[i] = 0; m_lfsr[i] = i + 1;
    end
  endfunction

  function automatic void model_write(input int prm, input int idx, input int val);
    case (prm)
      0: m_freq[idx] = val & 65535;
      1: begin m_vol[idx] = val & 15; m_wave[idx] = (val >> 4) & 3; end
      2: m_duty[idx] = val & 255;
      default: begin
        m_en[idx] = val & 1;
        if ((val & 2) != 0) m_phase[idx] = 0;
      end
    endcase
  endfunction

  function automatic int model_sample();
    int sum, p, q, t, w, x, np, fb;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_en[i] != 0) begin
        p = m_phase[i] / 256;
        case (m_wave[i])
          0: w = (p < m_duty[i]) ? 127 : -128;
          1: w = p - 128;
          2: begin
            q = (m_phase[i] / 128) % 256;
            t = (m_phase[i] >= 32768) ? 255 - q : q;
            w = t - 128;
          end
          default: begin
            x = m_lfsr[i] % 256;
            w = (x >= 128) ? x - 256 : x;
          end
        endcase
        sum += w * m_vol[i];
        np = m_phase[i] + m_freq[i];
        if (np >= 65536) begin
          fb = ((m_lfsr[i] >> 14) ^ (m_lfsr[i] >> 13)) & 1;
          m_lfsr[i] = ((m_lfsr[i] * 2) + fb) % 32768;
        end
        m_phase[i] = np % 65536;
      end
    end
    return sum * 4;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_irq();
    logic exp_irq;
`ifdef SND_FRAME_IRQ_EN
    exp_irq = ((stb_cnt % FRAME_SAMPLES) == 0);
`else
    exp_irq = 1'b0;
`endif
    check("frame_irq", frame_irq, exp_irq);
  endtask

  // Waits (bounded) for the next strobe; checks frame_irq stays low in between.
  task automatic wait_stb(output logic ok);
    int c;
    ok = 1'b0;
    c = 0;
    while (!ok && c < 4 * CLK_DIV) begin
      @(posedge clk); #1;
      c++;
      if (sample_stb) ok = 1'b1;
      else check("frame_irq_quiet", frame_irq, 0);
    end
    if (!ok) check("stb_timeout", 0, 1);
    else begin
      stb_cnt++;
      check_irq();
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called in a strobe cycle: optional write, then check the following sample.
  task automatic step(input string tag, input logic do_wr, input int prm, input int idx,
                      input int val, output logic [15:0] obs);
    logic ok;
    logic [15:0] e;
    if (do_wr) begin
      snd_wen = 1'b1; w_param = prm[1:0]; w_index = idx[1:0]; w_val = val[15:0];
      model_write(prm, idx, val);
    end
    exp_q.push_back(16'(model_sample()));
    if (do_wr) begin
      @(posedge clk); #1;
      snd_wen = 1'b0;
    end
    wait_stb(ok);
    e = exp_q.pop_front();
    obs = sample;
    if (ok) check(tag, sample, e);
  endtask

  task automatic do_reset(input int nlow);
    int cyc;
    logic got;
    resetn = 1'b0;
    snd_wen = 1'b0;
    repeat (nlow) begin @(posedge clk); #1; end
    check("rst_sample", sample, 0);
    check("rst_stb", sample_stb, 0);
    check("rst_irq", frame_irq, 0);
    model_reset();
    exp_q.delete();
    stb_cnt = 0;
    resetn = 1'b1;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (sample_stb) got = 1'b1;
    end
    check("first_stb_cycle", cyc, 11);
    if (got) begin
      stb_cnt++;
      check_irq();
      check("first_sample_model", sample, 16'(model_sample()));
      check("first_sample_zero", sample, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] obs;
  logic [15:0] sq_lit[8];
  logic [15:0] dis_lit[7];
  logic [15:0] clr_lit[3];
  logic        ok;

  initial begin
    sq_lit  = '{16'h1DC4, 16'h1DC4, 16'hE200, 16'hE200, 16'h1DC4, 16'h1DC4, 16'hE200, 16'hE200};
    dis_lit = '{16'h1DC4, 16'h1DC4, 16'h0000, 16'h0000, 16'hE200, 16'hE200, 16'h1DC4};
    clr_lit = '{16'h1DC4, 16'h1DC4, 16'hE200};

    do_reset(3);

    // Square on voice 0.
    step("sq_cfg", 1'b1, 0, 0, 16'h4000, obs);
    step("sq_cfg", 1'b1, 1, 0, 16'h000F, obs);
    step("sq_cfg", 1'b1, 2, 0, 16'h0080, obs);
    step("sq", 1'b1, 3, 0, 16'h0001, obs);
    check("sq_lit", obs, sq_lit[0]);
    for (int k = 1; k < 8; k++) begin
      step("sq", 1'b0, 0, 0, 0, obs);
      check("sq_lit", obs, sq_lit[k]);
    end

    // Four saw voices at FREQ 0.
    do_reset(3);
    for (int v = 0; v < 4; v++) step("saw_cfg", 1'b1, 1, v, 16'h001F, obs);
    for (int v = 0; v < 4; v++) step("saw_en", 1'b1, 3, v, 16'h0001, obs);
    check("saw_lit", obs, 16'h8800);
    for (int k = 0; k < 3; k++) begin
      step("saw", 1'b0, 0, 0, 0, obs);
      check("saw_lit", obs, 16'h8800);
    end

    // Voice 1: enable, disable, re-enable.
    do_reset(3);
    step("dis_cfg", 1'b1, 0, 1, 16'h4000, obs);
    step("dis_cfg", 1'b1, 1, 1, 16'h000F, obs);
    step("dis_cfg", 1'b1, 2, 1, 16'h0080, obs);
    step("dis", 1'b1, 3, 1, 16'h0001, obs); check("dis_lit", obs, dis_lit[0]);
    step("dis", 1'b0, 0, 0, 0, obs);        check("dis_lit", obs, dis_lit[1]);
    step("dis", 1'b1, 3, 1, 16'h0000, obs); check("dis_lit", obs, dis_lit[2]);
    step("dis", 1'b0, 0, 0, 0, obs);        check("dis_lit", obs, dis_lit[3]);
    step("dis", 1'b1, 3, 1, 16'h0001, obs); check("dis_lit", obs, dis_lit[4]);
    step("dis", 1'b0, 0, 0, 0, obs);        check("dis_lit", obs, dis_lit[5]);
    step("dis", 1'b0, 0, 0, 0, obs);        check("dis_lit", obs, dis_lit[6]);

    // Phase clear written during voice 0's own update cycle.
    do_reset(3);
    step("clr_cfg", 1'b1, 0, 0, 16'h4000, obs);
    step("clr_cfg", 1'b1, 1, 0, 16'h000F, obs);
    step("clr_cfg", 1'b1, 2, 0, 16'h0080, obs);
    step("clr_cfg", 1'b1, 3, 0, 16'h0001, obs);
    step("clr_cfg", 1'b0, 0, 0, 0, obs);
    exp_q.push_back(16'(model_sample()));
    model_write(3, 0, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    snd_wen = 1'b1; w_param = 2'd3; w_index = 2'd0; w_val = 16'h0003;
    @(posedge clk); #1;
    snd_wen = 1'b0;
    wait_stb(ok);
    if (ok) begin
      check("clr_cur", sample, exp_q.pop_front());
      check("clr_cur_lit", sample, 16'hE200);
    end
    for (int k = 0; k < 3; k++) begin
      step("clr", 1'b0, 0, 0, 0, obs);
      check("clr_lit", obs, clr_lit[k]);
    end

    // Randomized writes, one per sample period.
    do_reset(3);
    for (int k = 0; k < 150; k++) begin
      int prm, idx, val;
      logic wr;
      wr  = ($urandom_range(0, 3) != 0);
      prm = $urandom_range(0, 3);
      idx = $urandom_range(0, 3);
      case (prm)
        0: val = $urandom_range(0, 65535);
        1: val = $urandom_range(0, 63);
        2: val = $urandom_range(0, 255);
        default: val = $urandom_range(0, 3) | (($urandom_range(0, 3) != 0) ? 1 : 0);
      endcase
      step("rand", wr, prm, idx, val, obs);
    end

    // Reset asserted mid-scan, then normal operation resumes.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset(3);
    step("post_rst", 1'b1, 3, 2, 16'h0001, obs);
    step("post_rst", 1'b0, 0, 0, 0, obs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
